cc_unit: RTL and testbench

//  Parametrised Y86-64 condition-code unit for the execute stage. Computes ZF/SF/OF from
//  the ALU operands/result, latches them under set/suppress control, and evaluates
//  jXX/cmovXX conditions from the registered flags. Replaces the bare 3-bit CC register.

---
 rtl/cc_unit.sv | 101 ++++++++++
 tb/tb_cc_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cc_unit.sv
// cc_unit: Y86-64 condition-code unit for the execute stage.
// Derives {ZF,SF,OF} from the ALU operands and result, commits them to the
// flag register when an update is allowed, and evaluates jXX/cmovXX
// conditions from the registered flags only. There is no bypass.
module cc_unit #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] RESET_CC = 3'b100
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             set,
  input  logic             suppress,
  input  logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       ifun,
  output logic [2:0]       cc_out,
  output logic             cond,
  output logic             cc_valid,
  output logic             upd_err
);

  logic       req;
  logic       fun_legal;
  logic       do_update;
  logic       bad_update;
  logic       a_s;
  logic       b_s;
  logic       r_s;
  logic       zf_new;
  logic       sf_new;
  logic       of_new;
  logic [2:0] cc_new;
  logic       zf;
  logic       sf;
  logic       of;

  assign req        = set & ~suppress;
  assign fun_legal  = (alu_fun <= 4'd3);
  assign do_update  = req & fun_legal;
  assign bad_update = req & ~fun_legal;

  assign a_s = alu_a[WIDTH-1];
  assign b_s = alu_b[WIDTH-1];
  assign r_s = alu_out[WIDTH-1];

  // Candidate flags from the current ALU operands and result
  always_comb begin
    zf_new = (alu_out == {WIDTH{1'b0}});
    sf_new = r_s;
    of_new = 1'b0;
    case (alu_fun)
      4'd0:    of_new = (a_s == b_s) & (r_s != a_s);   // add: a + b
      4'd1:    of_new = (a_s != b_s) & (r_s != b_s);   // sub: b - a
      4'd2:    of_new = 1'b0;                          // and
      4'd3:    of_new = 1'b0;                          // xor
      default: of_new = 1'b0;                          // illegal: never committed
    endcase
  end

  assign cc_new = {zf_new, sf_new, of_new};

  // Flag register, sticky valid bit and one-cycle illegal-update pulse
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      cc_out   <= RESET_CC;
      cc_valid <= 1'b0;
      upd_err  <= 1'b0;
    end else begin
      upd_err <= bad_update;
      if (do_update) begin
        cc_out   <= cc_new;
        cc_valid <= 1'b1;
      end else begin
        cc_out   <= cc_out;
        cc_valid <= cc_valid;
      end
    end
  end

  assign zf = cc_out[2];
  assign sf = cc_out[1];
  assign of = cc_out[0];

  // Branch/cmov condition evaluated from the registered flags
  always_comb begin
    cond = 1'b0;
    case (ifun)
      4'd0:    cond = 1'b1;                    // always
      4'd1:    cond = (sf ^ of) | zf;          // le
      4'd2:    cond = sf ^ of;                 // l
      4'd3:    cond = zf;                      // e
      4'd4:    cond = ~zf;                     // ne
      4'd5:    cond = ~(sf ^ of);              // ge
      4'd6:    cond = ~(sf ^ of) & ~zf;        // g
      default: cond = 1'b0;                    // undefined codes
    endcase
  end

endmodule

// File: tb/tb_cc_unit.sv
// tb_cc_unit: scoreboard bench for cc_unit at WIDTH=64 and WIDTH=8.
// The stimulus process drives both instances on the falling edge and
// pushes the state expected after the next rising edge; the monitor
// pops and compares just after each rising edge.
module tb_cc_unit;

  logic        clk;
  logic        async_reset;
  logic        set;
  logic        suppress;
  logic [3:0]  alu_fun;
  logic [3:0]  ifun;
  logic [63:0] a64, b64, r64;
  logic [7:0]  a8, b8, r8;
  logic [2:0]  cc64, cc8;
  logic        cond64, cond8, valid64, valid8, err64, err8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] c64;
    logic [2:0] c8;
    logic       v;
    logic       e;
    logic [3:0] f;
  } exp_t;

  exp_t sbq[$];

  // reference state
  logic [2:0] m_cc64, m_cc8;
  logic       m_valid;

  cc_unit #(.WIDTH(64), .RESET_CC(3'b100)) dut64 (
    .clk(clk), .async_reset(async_reset), .set(set), .suppress(suppress),
    .alu_fun(alu_fun), .alu_a(a64), .alu_b(b64), .alu_out(r64), .ifun(ifun),
    .cc_out(cc64), .cond(cond64), .cc_valid(valid64), .upd_err(err64));

  cc_unit #(.WIDTH(8), .RESET_CC(3'b100)) dut8 (
    .clk(clk), .async_reset(async_reset), .set(set), .suppress(suppress),
    .alu_fun(alu_fun), .alu_a(a8), .alu_b(b8), .alu_out(r8), .ifun(ifun),
    .cc_out(cc8), .cond(cond8), .cc_valid(valid8), .upd_err(err8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags from exact signed arithmetic: overflow means the true sum or
  // difference does not fit in a w-bit two's-complement number.
  function automatic logic [2:0] model_flags(int w, logic [3:0] fun,
                                             logic [63:0] a, logic [63:0] b, logic [63:0] r);
    logic signed [63:0] ta, tb;
    logic signed [65:0] ea, eb, ex, lo, hi;
    logic [63:0] mask;
    logic zf, sf, of;
    ta = $signed(a << (64 - w)) >>> (64 - w);
    tb = $signed(b << (64 - w)) >>> (64 - w);
    ea = ta;
    eb = tb;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    zf = ((r & mask) == 64'd0);
    sf = r[w-1];
    lo = -(66'sd1 <<< (w - 1));
    hi = (66'sd1 <<< (w - 1)) - 66'sd1;
    if (fun == 4'd0)      ex = ea + eb;
    else if (fun == 4'd1) ex = eb - ea;
    else                  ex = 66'sd0;
    of = (fun <= 4'd1) && ((ex < lo) || (ex > hi));
    return {zf, sf, of};
  endfunction

  function automatic logic [63:0] alu_res(int w, logic [3:0] fun, logic [63:0] a, logic [63:0] b);
    logic [63:0] r;
    logic [63:0] mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    case (fun)
      4'd0:    r = a + b;
      4'd1:    r = b - a;
      4'd2:    r = a & b;
      4'd3:    r = a ^ b;
      default: r = {$urandom, $urandom};
    endcase
    return r & mask;
  endfunction

  function automatic logic model_cond(logic [2:0] cc, logic [3:0] code);
    logic zf, sf, of, lt;
    zf = cc[2]; sf = cc[1]; of = cc[0];
    lt = (sf != of);
    case (code)
      4'd0:    return 1'b1;
      4'd1:    return lt || zf;
      4'd2:    return lt;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !lt;
      4'd6:    return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(string name, logic [3:0] got, logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // One stimulus cycle. pulse: short reset pulse between edges with
  // immediate checks; hold: reset held low across the next rising edge.
  task automatic step(logic s, logic sup, logic [3:0] fun,
                      logic [63:0] a, logic [63:0] b, logic [7:0] sa, logic [7:0] sb,
                      logic [3:0] code, bit pulse, bit hold);
    exp_t x;
    logic err;
    @(negedge clk);
    async_reset = hold ? 1'b0 : 1'b1;
    set = s; suppress = sup; alu_fun = fun; ifun = code;
    a64 = a; b64 = b; r64 = alu_res(64, fun, a, b);
    a8 = sa; b8 = sb; r8 = alu_res(8, fun, {56'd0, sa}, {56'd0, sb}) & 64'hFF;
    if (pulse) begin
      #2 async_reset = 1'b0;
      #1;
      check("pulse_cc64",   {1'b0, cc64}, 4'h4);
      check("pulse_cc8",    {1'b0, cc8}, 4'h4);
      check("pulse_valid",  {2'b00, valid64, valid8}, 4'h0);
      check("pulse_err",    {2'b00, err64, err8}, 4'h0);
      check("pulse_cond",   {2'b00, cond64, cond8}, {2'b00, {2{model_cond(3'b100, code)}}});
      async_reset = 1'b1;
      m_cc64 = 3'b100; m_cc8 = 3'b100; m_valid = 1'b0;
    end
    if (hold) begin
      m_cc64 = 3'b100; m_cc8 = 3'b100; m_valid = 1'b0;
      err = 1'b0;
    end else begin
      err = s && !sup && (fun > 4'd3);
      if (s && !sup && (fun <= 4'd3)) begin
        m_cc64 = model_flags(64, fun, a64, b64, r64);
        m_cc8  = model_flags(8, fun, {56'd0, a8}, {56'd0, b8}, {56'd0, r8});
        m_valid = 1'b1;
      end
    end
    x.c64 = m_cc64; x.c8 = m_cc8; x.v = m_valid; x.e = err; x.f = code;
    sbq.push_back(x);
  endtask

  // Monitor: compare the registered state just after every rising edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        check("cc64",   {1'b0, cc64}, {1'b0, x.c64});
        check("cc8",    {1'b0, cc8},  {1'b0, x.c8});
        check("valid",  {2'b00, valid64, valid8}, {2'b00, x.v, x.v});
        check("upd_err", {2'b00, err64, err8}, {2'b00, x.e, x.e});
        check("cond64", {3'b000, cond64}, {3'b000, model_cond(x.c64, x.f)});
        check("cond8",  {3'b000, cond8},  {3'b000, model_cond(x.c8, x.f)});
      end
    end
  end

  // Stimulus
  initial begin
    logic [63:0] ra, rb;
    logic [7:0]  qa, qb;
    logic [3:0]  fn;
    async_reset = 1'b0;
    set = 1'b0; suppress = 1'b0; alu_fun = 4'd0; ifun = 4'd0;
    a64 = 64'd0; b64 = 64'd0; r64 = 64'd0; a8 = 8'd0; b8 = 8'd0; r8 = 8'd0;
    m_cc64 = 3'b100; m_cc8 = 3'b100; m_valid = 1'b0;

    step(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 8'd0, 8'd0, 4'd3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 8'd0, 8'd0, 4'd3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 8'd0, 8'd0, 4'd3, 1'b1, 1'b0);
    // signed overflow on add
    step(1'b1, 1'b0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 8'h7F, 8'h01, 4'd2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 8'd0, 8'd0, 4'd6, 1'b0, 1'b0);
    // equal sub, then suppressed update producing -1
    step(1'b1, 1'b0, 4'd1, 64'd5, 64'd5, 8'd5, 8'd5, 4'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd1, 64'd1, 64'd0, 8'd1, 8'd0, 4'd3, 1'b0, 1'b0);
    // sub overflow: most-negative minus one
    step(1'b1, 1'b0, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 8'h01, 8'h80, 4'd2, 1'b0, 1'b0);
    // illegal function: flags hold, one-cycle error pulse
    step(1'b1, 1'b0, 4'd4, 64'd3, 64'd9, 8'd3, 8'd9, 4'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd4, 64'd3, 64'd9, 8'd3, 8'd9, 4'd5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd15, 64'd3, 64'd9, 8'd3, 8'd9, 4'd5, 1'b0, 1'b0);
    // back-to-back xor (zero) then and (sign bit only)
    step(1'b1, 1'b0, 4'd3, 64'h1234, 64'h1234, 8'h34, 8'h34, 4'd3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 8'h80, 8'h80, 4'd2, 1'b0, 1'b0);
    // reset held through an edge carrying a valid update
    step(1'b1, 1'b0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 8'h7F, 8'h01, 4'd3, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 8'h7F, 8'h01, 4'd2, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 5) == 0) ? ra : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = {rb[63], {63{~rb[63]}}};
      qa = ra[7:0];
      qb = rb[7:0];
      fn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), fn,
           ra, rb, qa, qb, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) == 0));
    end

    @(negedge clk);
    set = 1'b0;
    async_reset = 1'b1;
    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
